// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubbles, taken-branch flushes,
// data-memory freezes with a watchdog trap, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             id_ex_instr_rt,
    input  logic [4:0]             if_id_instr_rs,
    input  logic [4:0]             if_id_instr_rt,
    input  logic                   if_id_uses_rt,
    input  logic                   ex_branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_write,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_write,
    output logic                   mem_wb_bubble,
    output logic                   mem_timeout_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
    localparam logic [STALL_CNT_W-1:0] StallMax = '1;

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    state_e                 state_q, state_d;
    logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   err_q, err_d;

    logic load_use;
    logic mem_stall;
    logic timeout;

    logic dec_pc_write;
    logic dec_if_id_write;
    logic dec_if_id_flush;
    logic dec_id_ex_write;
    logic dec_id_ex_bubble;
    logic dec_ex_mem_write;
    logic dec_mem_wb_bubble;

    assign load_use = id_ex_mem_read && (id_ex_instr_rt != 5'd0) &&
                      ((id_ex_instr_rt == if_id_instr_rs) ||
                       (if_id_uses_rt && (id_ex_instr_rt == if_id_instr_rt)));

    assign mem_stall = dmem_req && !dmem_ready;
    assign timeout   = mem_stall && (wait_cnt_q == WaitLast);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (timeout) begin
                    state_d = StError;
                end else if (mem_stall) begin
                    state_d = StMemWait;
                end
            end
            StMemWait: begin
                if (timeout) begin
                    state_d = StError;
                end else if (!mem_stall) begin
                    state_d = StRun;
                end
            end
            StError: state_d = StError;
            default: state_d = StRun;
        endcase
    end

    // Output decode; RUN and MEM_WAIT share the same priority decode
    always_comb begin
        dec_pc_write      = 1'b1;
        dec_if_id_write   = 1'b1;
        dec_if_id_flush   = 1'b0;
        dec_id_ex_write   = 1'b1;
        dec_id_ex_bubble  = 1'b0;
        dec_ex_mem_write  = 1'b1;
        dec_mem_wb_bubble = 1'b0;
        if (state_q == StError || mem_stall) begin
            // Freeze everything upstream of MEM/WB; pending branch/load-use is held in place.
            dec_pc_write      = 1'b0;
            dec_if_id_write   = 1'b0;
            dec_id_ex_write   = 1'b0;
            dec_ex_mem_write  = 1'b0;
            dec_mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            dec_if_id_flush  = 1'b1;
            dec_id_ex_bubble = 1'b1;
        end else if (load_use) begin
            dec_pc_write     = 1'b0;
            dec_if_id_write  = 1'b0;
            dec_id_ex_bubble = 1'b1;
        end
    end

    // While reset is held the pipe registers are frozen and loaded with NOPs
    assign pc_write      = dec_pc_write && rst_n;
    assign if_id_write   = dec_if_id_write && rst_n;
    assign id_ex_write   = dec_id_ex_write && rst_n;
    assign ex_mem_write  = dec_ex_mem_write && rst_n;
    assign if_id_flush   = dec_if_id_flush || !rst_n;
    assign id_ex_bubble  = dec_id_ex_bubble || !rst_n;
    assign mem_wb_bubble = dec_mem_wb_bubble || !rst_n;

    assign mem_timeout_err = err_q;
    assign stall_cycles    = stall_cnt_q;

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        if (state_q != StError) begin
            wait_cnt_d = mem_stall ? wait_cnt_q + WaitW'(1) : '0;
            if (!dec_pc_write && (stall_cnt_q != StallMax)) begin
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
            if (timeout) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: decode table in RUN plus hand sequences for memory
// wait, watchdog trap, asynchronous reset and counter saturation.
module tb_hazard_stall_ctrl;

    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    //                       ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] MEM  = 7'b0000001;
    localparam logic [6:0] RST  = 7'b0010101;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic id_ex_mem_read, if_id_uses_rt, ex_branch_taken, dmem_req, dmem_ready;
    logic [4:0] id_ex_instr_rt, if_id_instr_rs, if_id_instr_rt;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write;
    logic mem_wb_bubble, mem_timeout_err;
    logic [15:0] stall_cycles;
    logic s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_bubble;
    logic s_ex_mem_write, s_mem_wb_bubble, s_mem_timeout_err;
    logic [3:0] s_stall_cycles;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(16), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_instr_rt(id_ex_instr_rt),
        .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
        .if_id_uses_rt(if_id_uses_rt), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .mem_wb_bubble(mem_wb_bubble), .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.MEM_TIMEOUT(16), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_instr_rt(id_ex_instr_rt),
        .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
        .if_id_uses_rt(if_id_uses_rt), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_write(s_id_ex_write), .id_ex_bubble(s_id_ex_bubble),
        .ex_mem_write(s_ex_mem_write), .mem_wb_bubble(s_mem_wb_bubble),
        .mem_timeout_err(s_mem_timeout_err), .stall_cycles(s_stall_cycles)
    );

    typedef struct {
        logic       mr;
        logic [4:0] ld_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [6:0] exp);
        chk(name, {25'd0, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                   ex_mem_write, mem_wb_bubble}, {25'd0, exp});
    endtask

    task automatic drive(input logic mr, input logic [4:0] ld_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses, input logic br,
                         input logic req, input logic rdy);
        id_ex_mem_read  = mr;
        id_ex_instr_rt  = ld_rt;
        if_id_instr_rs  = rs;
        if_id_instr_rt  = rt;
        if_id_uses_rt   = uses;
        ex_branch_taken = br;
        dmem_req        = req;
        dmem_ready      = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[1]  = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[2]  = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[3]  = '{1'b1, 5'd5,  5'd3, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[4]  = '{1'b1, 5'd5,  5'd3, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, LU};
        vecs[5]  = '{1'b0, 5'd5,  5'd5, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, NORM};
        vecs[6]  = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, BR};
        vecs[7]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, BR};
        vecs[8]  = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, LU};
        vecs[9]  = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, MEM};
        vecs[10] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, NORM};
        vecs[11] = '{1'b1, 5'd31, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, LU};
        vecs[12] = '{1'b1, 5'd7,  5'd8, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, NORM};

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_outs("reset_outputs", RST);
        chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("reset_err", 32'(mem_timeout_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk_outs("release_outputs", NORM);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].mr, vecs[i].ld_rt, vecs[i].rs, vecs[i].rt, vecs[i].uses,
                  vecs[i].br, vecs[i].req, vecs[i].rdy);
            #3;
            chk_outs($sformatf("vec%0d_outs", i), vecs[i].exp);
            tick();
            if (vecs[i].exp[6] == 1'b0) exp_cnt++;
            chk($sformatf("vec%0d_stall_cycles", i), 32'(stall_cycles), 32'(exp_cnt));
        end

        // Three-cycle memory wait with a taken branch pending, released with the branch applied
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            #3;
            chk_outs($sformatf("memwait%0d_outs", k), MEM);
            tick();
            exp_cnt++;
        end
        chk("memwait_stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        #3;
        chk_outs("memwait_release_branch", BR);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk_outs("memwait_after_run", NORM);
        chk("memwait_err", 32'(mem_timeout_err), 32'd0);
        chk("memwait_release_cnt", 32'(stall_cycles), 32'(exp_cnt));
        tick();

        // Watchdog: 16 consecutive stall edges trap
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #3;
            chk_outs($sformatf("wd%0d_outs", k), MEM);
            tick();
            exp_cnt++;
            chk($sformatf("wd%0d_err", k), 32'(mem_timeout_err), (k == 16) ? 32'd1 : 32'd0);
        end
        chk("wd_stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #3;
        chk_outs("error_outs", MEM);
        tick();
        chk("error_no_count", 32'(stall_cycles), 32'(exp_cnt));
        chk("error_sticky", 32'(mem_timeout_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_err", 32'(mem_timeout_err), 32'd0);
        chk("async_reset_cnt", 32'(stall_cycles), 32'd0);
        chk_outs("async_reset_outs", RST);
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk_outs("post_error_run", NORM);
        tick();

        // wait_cnt must have been cleared by reset: a 15-cycle wait does not trap
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            exp_cnt++;
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #3;
        chk_outs("wait15_release", NORM);
        tick();
        chk("wait15_err", 32'(mem_timeout_err), 32'd0);
        chk("wait15_cnt", 32'(stall_cycles), 32'(exp_cnt));

        // Saturation on the 4-bit counter instance
        rst_n = 1'b0;
        #1;
        chk("sat_reset_cnt", 32'(s_stall_cycles), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("sat_cnt_w4", 32'(s_stall_cycles), 32'd15);
        chk("sat_cnt_w16", 32'(stall_cycles), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core; it sequences the pipeline-register write enables alongside the forwarding unit. It covers the cases forwarding cannot resolve:
- load-use hazards, by inserting one bubble;
- taken branches resolved in EX, by flushing IF/ID and ID/EX;
- data-memory wait states, by freezing the pipe.

A watchdog traps a memory access that never completes, and a saturating counter reports total stall cycles for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max consecutive data-memory stall cycles before trapping (≥2).
- STALL_CNT_W, 16: width of stall_cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_instr_rt  in  5  load destination register
- if_id_instr_rs  in  5  rs of instruction in ID
- if_id_instr_rt  in  5  rt of instruction in ID
- if_id_uses_rt  in  1  ID instruction reads rt as a source
- ex_branch_taken  in  1  branch in EX resolved taken (PC mux selects target)
- dmem_req  in  1  EX/MEM stage performs a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_write  out  1  ID/EX load enable
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits cleared)
- ex_mem_write  out  1  EX/MEM load enable
- mem_wb_bubble  out  1  MEM/WB loads a NOP
- mem_timeout_err  out  1  sticky watchdog trap
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0

## Operation
- load_use = id_ex_mem_read & (id_ex_instr_rt≠0) & ((id_ex_instr_rt==if_id_instr_rs) | (if_id_uses_rt & id_ex_instr_rt==if_id_instr_rt)).
- mem_stall = dmem_req & !dmem_ready.
- FSM states: RUN, MEM_WAIT, ERROR.
- Output decode in RUN/MEM_WAIT, strict priority:
  1. mem_stall: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble=1; flush/bubble=0. A pending branch or load-use is held frozen and resolved after release.
  2. ex_branch_taken: all writes=1; if_id_flush=1, id_ex_bubble=1; load_use ignored (wrong-path instruction).
  3. load_use: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1, ex_mem_write=1.
  4. Otherwise all writes=1, all flush/bubble=0.
- ERROR: all writes 0, mem_wb_bubble=1, other flush/bubble 0, mem_timeout_err=1. Left only by reset.
- wait_cnt is internal, width $clog2(MEM_TIMEOUT+1):
  - increments on each mem_stall cycle;
  - clears on any cycle without mem_stall.
- Transitions:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN on !mem_stall. That cycle decodes normally, so the pipe advances in the ready cycle.
  - RUN/MEM_WAIT→ERROR when mem_stall & wait_cnt==MEM_TIMEOUT-1.
- stall_cycles increments on each cycle in RUN/MEM_WAIT with pc_write=0 and holds at all-ones. It does not count in ERROR.

## Timing
- All enable/flush outputs are combinational from the current state and inputs, valid in the same cycle. State, wait_cnt, stall_cycles and mem_timeout_err update on posedge clk.
- Load-use costs exactly 1 cycle: after the bubble, ID/EX no longer holds a load, so the hazard does not re-detect.
- Taken branch costs 2 squashed instructions.
- Memory wait of N cycles costs N stall cycles. dmem_ready in the same cycle as the request costs 0.
- Reset (rst_n=0, asynchronous, any state, including mid-wait or ERROR):
  - state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout_err=0;
  - pc_write, if_id_write, id_ex_write, ex_mem_write forced 0;
  - if_id_flush, id_ex_bubble, mem_wb_bubble forced 1.
- Reset release: first edge with rst_n=1 resumes normal decode.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_instr_rt=5, if_id_instr_rs=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles 0→1. Repeat with rt=0 -> no stall.
- rt-only match: if_id_instr_rt=5 with if_id_uses_rt=0 -> no stall; with if_id_uses_rt=1 -> stall.
- Branch vs load-use: ex_branch_taken=1 with load_use true -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_cycles unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> all writes 0 and mem_wb_bubble=1 for 3 cycles; 4th cycle writes=1; state back to RUN; stall_cycles +3. Branch asserted during the wait is applied in the release cycle.
- Watchdog: MEM_TIMEOUT=16, dmem_ready held 0 -> mem_timeout_err=1 after the 16th stall edge; writes stay 0 thereafter. Asserting rst_n=0 mid-ERROR clears err and counters immediately.
- Saturation: STALL_CNT_W=4, 20 load-use stalls -> stall_cycles holds at 15.
